// File: rtl/processor_pkg.sv
// processor_pkg: shared constants for the processor_core slice.
//   - icode_e      : instruction class encodings (NOP, IRMOV, RRMOV, OP, HALT)
//   - ALU_*        : OP ifun encodings (ADD, SUB, AND, XOR)
//   - REG_NONE     : "no register" ID
//   - *_LSB        : instruction field positions
//   - CC_*         : bit positions inside the {ZF,SF,OF} condition-code vector
package processor_pkg;

    typedef enum logic [3:0] {
        IcNop   = 4'h0,
        IcIrmov = 4'h1,
        IcRrmov = 4'h2,
        IcOp    = 4'h6,
        IcHalt  = 4'hF
    } icode_e;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_XOR = 4'h3;

    localparam logic [3:0] REG_NONE = 4'hF;

    localparam int unsigned ICODE_LSB = 28;
    localparam int unsigned IFUN_LSB  = 24;
    localparam int unsigned RA_LSB    = 20;
    localparam int unsigned RB_LSB    = 16;
    localparam int unsigned VALC_LSB  = 0;

    localparam int unsigned CC_ZF = 2;
    localparam int unsigned CC_SF = 1;
    localparam int unsigned CC_OF = 0;

    // IDs 8..F all behave like REG_NONE, so bit 3 alone decides validity.
    function automatic logic reg_valid(input logic [3:0] id);
        return !id[3];
    endfunction

endpackage

// File: rtl/processor_if.sv
// processor_if: host/observation bus of processor_core.
//   master (host) drives : addr, wr, wdata, working, rID
//   slave  (core) drives : valE, r0..r7, rdata, cc
interface processor_if;

    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        working;
    logic [3:0]  rID;

    logic [31:0] valE;
    logic [31:0] r0, r1, r2, r3, r4, r5, r6, r7;
    logic [31:0] rdata;
    logic [2:0]  cc;

    modport master (
        output addr, wr, wdata, working, rID,
        input  valE, r0, r1, r2, r3, r4, r5, r6, r7, rdata, cc
    );

    modport slave (
        input  addr, wr, wdata, working, rID,
        output valE, r0, r1, r2, r3, r4, r5, r6, r7, rdata, cc
    );

endinterface

// File: rtl/processor_alu.sv
// processor_alu: combinational ALU for OP instructions.
//   i_a, i_b  : operands (rA value, rB value); result is i_b op i_a
//   i_ifun    : 0 add, 1 sub, 2 and, 3 xor, anything else add
//   o_result  : 32-bit result
//   o_zf/o_sf/o_of : zero, sign, signed overflow (overflow is 0 for and/xor)
module processor_alu
    import processor_pkg::*;
(
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic [3:0]  i_ifun,
    output logic [31:0] o_result,
    output logic        o_zf,
    output logic        o_sf,
    output logic        o_of
);

    logic [31:0] w_sum;
    logic [31:0] w_diff;

    assign w_sum  = i_b + i_a;
    assign w_diff = i_b - i_a;

    always_comb begin
        o_result = w_sum;
        o_of     = (i_a[31] == i_b[31]) && (w_sum[31] != i_a[31]);
        case (i_ifun)
            ALU_SUB: begin
                o_result = w_diff;
                // b - a overflows when operand signs differ and the sign of b is lost
                o_of     = (i_a[31] != i_b[31]) && (w_diff[31] != i_b[31]);
            end
            ALU_AND: begin
                o_result = i_b & i_a;
                o_of     = 1'b0;
            end
            ALU_XOR: begin
                o_result = i_b ^ i_a;
                o_of     = 1'b0;
            end
            default: ;
        endcase
    end

    assign o_zf = (o_result == 32'h0);
    assign o_sf = o_result[31];

endmodule

// File: rtl/processor_core.sv
// processor_core: single-cycle Y86-style core with on-chip instruction memory.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   bus (slave)  : host loads imem (addr/wr/wdata) while working=0; working=1 executes
//                  one instruction per clock from PC 0; valE, r0..r7, cc, rdata observe.
// Optional: define PROC_HALT_EN to make icode 0xF a sticky HALT (otherwise it is a NOP).
module processor_core
    import processor_pkg::*;
#(
    parameter int unsigned IMEM_DEPTH = 256
) (
    input  logic       clock,
    input  logic       reset,
    processor_if.slave bus
);

    localparam int unsigned AW = $clog2(IMEM_DEPTH);

    logic [31:0]   r_imem [IMEM_DEPTH];
    logic [AW-1:0] r_pc;
    logic [31:0]   r_regs [8];
    logic [2:0]    r_cc;

    logic [AW-1:0] w_host_idx;
    logic          w_unused_addr;
    logic [31:0]   w_instr;
    icode_e        w_icode;
    logic [3:0]    w_ifun;
    logic [3:0]    w_ra;
    logic [3:0]    w_rb;
    logic [15:0]   w_valc;
    logic [31:0]   w_val_a;
    logic [31:0]   w_val_b;
    logic [31:0]   w_alu_res;
    logic          w_zf, w_sf, w_of;
    logic [31:0]   w_val_e;
    logic          w_reg_we;
    logic          w_cc_we;
    logic          w_halt;
    logic          w_commit;

    assign w_host_idx    = bus.addr[AW-1:0];
    assign w_unused_addr = ^bus.addr[31:AW];

    // Host load port; imem is deliberately outside the reset domain.
    always_ff @(posedge clock) begin
        if (bus.wr && !bus.working) begin
            r_imem[w_host_idx] <= bus.wdata;
        end
    end

    assign w_instr = r_imem[r_pc];
    assign w_icode = icode_e'(w_instr[ICODE_LSB +: 4]);
    assign w_ifun  = w_instr[IFUN_LSB +: 4];
    assign w_ra    = w_instr[RA_LSB +: 4];
    assign w_rb    = w_instr[RB_LSB +: 4];
    assign w_valc  = w_instr[VALC_LSB +: 16];

    assign w_val_a = reg_valid(w_ra) ? r_regs[w_ra[2:0]] : 32'h0;
    assign w_val_b = reg_valid(w_rb) ? r_regs[w_rb[2:0]] : 32'h0;

    processor_alu u_alu (
        .i_a      (w_val_a),
        .i_b      (w_val_b),
        .i_ifun   (w_ifun),
        .o_result (w_alu_res),
        .o_zf     (w_zf),
        .o_sf     (w_sf),
        .o_of     (w_of)
    );

    always_comb begin
        w_val_e  = 32'h0;
        w_reg_we = 1'b0;
        w_cc_we  = 1'b0;
        w_halt   = 1'b0;
        case (w_icode)
            IcIrmov: begin
                w_val_e  = {16'h0, w_valc};
                w_reg_we = 1'b1;
            end
            IcRrmov: begin
                w_val_e  = w_val_a;
                w_reg_we = 1'b1;
            end
            IcOp: begin
                w_val_e  = w_alu_res;
                w_reg_we = 1'b1;
                w_cc_we  = 1'b1;
            end
`ifdef PROC_HALT_EN
            IcHalt: w_halt = 1'b1;
`endif
            default: ;
        endcase
        // Writes to REG_NONE (and 8..E) are dropped.
        if (!reg_valid(w_rb)) begin
            w_reg_we = 1'b0;
        end
    end

`ifdef PROC_HALT_EN
    logic r_halted;
    assign w_commit = bus.working && !r_halted;
`else
    assign w_commit = bus.working;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc <= '0;
            r_cc <= 3'b000;
            for (int i = 0; i < 8; i++) begin
                r_regs[i] <= 32'h0;
            end
`ifdef PROC_HALT_EN
            r_halted <= 1'b0;
`endif
        end else if (w_commit) begin
`ifdef PROC_HALT_EN
            if (w_halt) begin
                r_halted <= 1'b1;
            end else begin
                r_pc <= r_pc + AW'(1);
            end
`else
            r_pc <= r_pc + AW'(1);
`endif
            if (w_reg_we) begin
                r_regs[w_rb[2:0]] <= w_val_e;
            end
            if (w_cc_we) begin
                r_cc[CC_ZF] <= w_zf;
                r_cc[CC_SF] <= w_sf;
                r_cc[CC_OF] <= w_of;
            end
        end
    end

    assign bus.valE  = w_val_e;
    assign bus.cc    = r_cc;
    assign bus.r0    = r_regs[0];
    assign bus.r1    = r_regs[1];
    assign bus.r2    = r_regs[2];
    assign bus.r3    = r_regs[3];
    assign bus.r4    = r_regs[4];
    assign bus.r5    = r_regs[5];
    assign bus.r6    = r_regs[6];
    assign bus.r7    = r_regs[7];
    assign bus.rdata = bus.rID[3] ? r_imem[w_host_idx] : r_regs[bus.rID[2:0]];

endmodule

// File: tb/tb_processor_core.sv
// tb_processor_core: directed-vector bench for processor_core with hand-computed expectations.
module tb_processor_core;

    logic clock;
    logic reset;
    int   n_vec;
    int   n_miss;

    processor_if bus ();

    processor_core #(
        .IMEM_DEPTH (256)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_out(input int i);
        case (i)
            0: return bus.r0;
            1: return bus.r1;
            2: return bus.r2;
            3: return bus.r3;
            4: return bus.r4;
            5: return bus.r5;
            6: return bus.r6;
            7: return bus.r7;
            default: return 32'h0;
        endcase
    endfunction

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        bus.addr  = a;
        bus.wdata = d;
        bus.wr    = 1'b1;
        @(posedge clock);
        #1;
        bus.wr    = 1'b0;
    endtask

    task automatic run(input int n);
        bus.working = 1'b1;
        repeat (n) @(posedge clock);
        #1;
        bus.working = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    logic [31:0] prog [30];
    logic [31:0] exp_regs [8];

    initial begin
        n_vec       = 0;
        n_miss      = 0;
        reset       = 1'b1;
        bus.addr    = 32'h0;
        bus.wr      = 1'b0;
        bus.wdata   = 32'h0;
        bus.working = 1'b0;
        bus.rID     = 4'h0;

        // Reset state
        #1;
        check("reset_r0", bus.r0, 32'h0);
        check("reset_r7", bus.r7, 32'h0);
        check("reset_cc", {29'h0, bus.cc}, 32'h0);
        @(negedge clock);
        reset = 1'b0;

        // Load scenario: IRMOV rI = 0x80+I
        for (int i = 0; i < 8; i++) begin
            load(32'(i), 32'h10F0_0080 + 32'(i) * 32'h0001_0001);
        end
        check("load_valE_pc0", bus.valE, 32'h0000_0080);
        run(8);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("load_r%0d", i), reg_out(i), 32'h80 + 32'(i));
        end
        check("load_cc", {29'h0, bus.cc}, 32'h0);
        bus.rID = 4'h3;
        #1;
        check("dbg_rdata_r3", bus.rdata, 32'h0000_0083);

        // Reset mid-run: clears asynchronously, imem survives, restarts at PC 0
        bus.working = 1'b1;
        repeat (3) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_r0", bus.r0, 32'h0);
        check("midrst_r2", bus.r2, 32'h0);
        bus.rID  = 4'hF;
        bus.addr = 32'h2;
        #1;
        check("midrst_imem2", bus.rdata, 32'h10F2_0082);
        @(posedge clock);
        #1;
        check("rst_held_r0", bus.r0, 32'h0);
        reset = 1'b0;
        @(posedge clock);
        #1;
        bus.working = 1'b0;
        check("restart_r0", bus.r0, 32'h0000_0080);
        check("restart_r1", bus.r1, 32'h0);
        bus.rID = 4'h0;

        // Program for OP / RRMOV / REG_NONE cases
        prog[0]  = 32'h10F0_0005;
        prog[1]  = 32'h10F1_0003;
        prog[2]  = 32'h6010_0000;  // add r1 -> r0
        prog[3]  = 32'h10F0_0003;
        prog[4]  = 32'h10F1_0003;
        prog[5]  = 32'h6110_0000;  // sub r0 = r0 - r1
        prog[6]  = 32'h10F0_8000;
        prog[7]  = 32'h10F1_0001;
        for (int i = 8; i < 24; i++) prog[i] = 32'h6000_0000;  // r0 += r0
        prog[24] = 32'h6110_0000;  // sub r0 = r0 - 1
        prog[25] = 32'h10F2_1234;
        prog[26] = 32'h2025_0000;  // rrmov r2 -> r5
        prog[27] = 32'h10FF_BEEF;  // irmov to REG_NONE
        prog[28] = 32'h6325_0000;  // xor r5 ^= r2
        prog[29] = 32'h6220_0000;  // and r0 &= r2

        pulse_reset();
        for (int i = 0; i < 30; i++) load(32'(i), prog[i]);

        run(2);
        check("add_valE", bus.valE, 32'h8);
        run(1);
        check("add_r0", bus.r0, 32'h8);
        check("add_cc", {29'h0, bus.cc}, 32'h0);

        run(3);
        check("sub_r0", bus.r0, 32'h0);
        check("sub_cc", {29'h0, bus.cc}, 32'h4);

        run(2);
        check("ovf_seed_r0", bus.r0, 32'h0000_8000);
        check("ovf_cc_hold", {29'h0, bus.cc}, 32'h4);
        run(16);
        check("dbl_r0", bus.r0, 32'h8000_0000);
        check("dbl_cc", {29'h0, bus.cc}, 32'h3);
        check("ovf_valE", bus.valE, 32'h7FFF_FFFF);
        run(1);
        check("ovf_r0", bus.r0, 32'h7FFF_FFFF);
        check("ovf_cc", {29'h0, bus.cc}, 32'h1);

        run(2);
        check("rrmov_r5", bus.r5, 32'h0000_1234);
        check("none_valE", bus.valE, 32'h0000_BEEF);
        run(1);
        exp_regs[0] = 32'h7FFF_FFFF;
        exp_regs[1] = 32'h1;
        exp_regs[2] = 32'h1234;
        exp_regs[3] = 32'h0;
        exp_regs[4] = 32'h0;
        exp_regs[5] = 32'h1234;
        exp_regs[6] = 32'h0;
        exp_regs[7] = 32'h0;
        for (int i = 0; i < 8; i++) begin
            check($sformatf("none_r%0d", i), reg_out(i), exp_regs[i]);
        end
        check("none_cc", {29'h0, bus.cc}, 32'h1);

        run(1);
        check("xor_r5", bus.r5, 32'h0);
        check("xor_cc", {29'h0, bus.cc}, 32'h4);

        // Host write attempted while working must be ignored
        bus.addr  = 32'h0;
        bus.wdata = 32'hDEAD_BEEF;
        bus.wr    = 1'b1;
        run(1);
        bus.wr    = 1'b0;
        check("and_r0", bus.r0, 32'h0000_1234);
        check("and_cc", {29'h0, bus.cc}, 32'h0);
        bus.rID = 4'hF;
        #1;
        check("wr_ignored", bus.rdata, 32'h10F0_0005);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
